mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single unified-memory port between the instruction cache and the data cache. It multiplexes one request per cycle onto the memory bus and returns the acceptance tag only to the granted cache. It records which cache owns each outstanding load tag and steers each tag return to the cache that issued the load. The block sits between `icache`/`dcache` and `mem`; the memory is always built with `CACHE_MODE` (64-bit transfers, no size field).

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied-Icache-request cycles after which the Icache gets priority for one cycle; legal range 1..15.
- `clock` input 1: single clock; all state updates on its posedge.
- `reset` input 1: asynchronous, active-high.
- `Icache2mem_command` input 2: BUS_NONE or BUS_LOAD. The Icache never issues BUS_STORE.
- `Icache2mem_addr` input `XLEN`: Icache line address, 8-byte aligned.
- `Dcache2mem_command` input 2: BUS_NONE, BUS_LOAD or BUS_STORE.
- `Dcache2mem_addr` input `XLEN`: Dcache address, 8-byte aligned.
- `Dcache2mem_data` input 64: store data.
- `mem2proc_response` input 4: memory acceptance tag; 0 means not accepted.
- `mem2proc_data` input 64: load return data.
- `mem2proc_tag` input 4: completing tag; 0 means nothing completes.
- `proc2mem_command` output 2: granted command.
- `proc2mem_addr` output `XLEN`: granted address.
- `proc2mem_data` output 64: equals `Dcache2mem_data` when the Dcache is granted, else 0.
- `mem2Icache_response` / `mem2Dcache_response` output 4 each: `mem2proc_response` for the granted side, 0 for the other side.
- `mem2Icache_data` / `mem2Dcache_data` output 64 each: `mem2proc_data` broadcast to both.
- `mem2Icache_tag` / `mem2Dcache_tag` output 4 each: `mem2proc_tag` routed to the owner, 0 to the other side.

## Operation
- **Grant (combinational):**
  - Dcache has priority whenever its command is not BUS_NONE.
  - Icache is granted when the Dcache is idle, or when the starve guard is active and the Icache is requesting.
  - With neither side requesting: command BUS_NONE, address 0, data 0.
- **Losing requester:** sees response 0, must hold its request and retry. The arbiter stores no requests.
- **Ownership table:** `valid[15:1]` and `owner[15:1]` (0 = Icache, 1 = Dcache).
  - At posedge, when a BUS_LOAD is granted and `mem2proc_response != 0`: set `valid[resp]` and `owner[resp]` = granted side.
  - Accepted stores allocate nothing; stores never produce a tag return.
- **Tag return:**
  - When `mem2proc_tag != 0` and `valid[tag]`: drive the tag on the owner's `mem2*_tag` output and clear `valid[tag]` at posedge.
  - A tag with `valid` = 0 is dropped, and both tag outputs are 0.
- **Same tag freed and reallocated in one cycle:** the allocation wins; `valid` stays 1 with the new owner.
- **Starve counter `starve_cnt` (4 bits):**
  - Increments each cycle the Icache requests and is not accepted (not granted, or granted with response 0).
  - Clears to 0 when the Icache is accepted or is not requesting.
  - Saturates at `STARVE_LIMIT`.
  - The guard is active while `starve_cnt == STARVE_LIMIT`.

## Timing
- Request to memory is zero latency: grant and the `proc2mem_*` mux are combinational from the cache commands.
- Acceptance and tag return reach the caches in the same cycle they leave memory; ownership lookup uses the table state at the start of that cycle.
- Table and counter changes are visible from the next cycle.
- **Reset (asynchronous):** clears `valid`, `owner` and `starve_cnt` to 0. While reset is high, every output is 0 (command BUS_NONE).
- **Reset in the middle of traffic:** loads still outstanding in memory lose ownership. Their later tag returns are dropped, and the caches are reset at the same time.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: the starve counter and guard are built as specified.
- Not defined:
  - No counter logic.
  - Strict Dcache priority.
  - `STARVE_LIMIT` is ignored.
  - Icache waits for as long as the Dcache keeps requesting.

## Test plan
- **Icache-only load:** Icache load 0x100, Dcache idle, mem response 3 → `proc2mem_addr` = 0x100 and `mem2Icache_response` = 3. After `MEM_LATENCY_IN_CYCLES`, tag 3 appears on `mem2Icache_tag` only, and `valid[3]` clears.
- **Simultaneous loads:** Icache 0x200 and Dcache 0x10 in the same cycle → Dcache granted, `mem2Icache_response` = 0. The next cycle, with Dcache idle, the Icache is granted. Both tags return to the correct caches.
- **Dcache store:** store addr 16, data 107 → `proc2mem_command` = BUS_STORE, `proc2mem_data` = 107, no table entry. After the memory wait, `unified_memory[2]` = 107.
- **Starve guard (macro defined, STARVE_LIMIT = 4):** Dcache requests continuously, Icache requests → Icache granted on the 5th cycle, then the counter returns to 0. With the macro undefined, the Icache is never granted.
- **Tag reuse:** tag 5 returns for the Icache in the same cycle tag 5 is accepted for a Dcache load → `mem2Icache_tag` = 5 that cycle, and the next return of 5 goes to the Dcache.
- **Reset with 2 outstanding loads:** assert reset → all outputs 0. The later returns of those tags are dropped, with both tag outputs 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing the unified memory port between icache and dcache.
// Optional Icache starve guard is built when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      Icache2mem_command,
  input  logic [XLEN-1:0] Icache2mem_addr,
  input  logic [1:0]      Dcache2mem_command,
  input  logic [XLEN-1:0] Dcache2mem_addr,
  input  logic [63:0]     Dcache2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2Icache_response,
  output logic [3:0]      mem2Dcache_response,
  output logic [63:0]     mem2Icache_data,
  output logic [63:0]     mem2Dcache_data,
  output logic [3:0]      mem2Icache_tag,
  output logic [3:0]      mem2Dcache_tag
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  logic [15:1] valid;
  logic [15:1] owner;   // 0 = Icache, 1 = Dcache

  logic i_req, d_req, guard, grant_i, grant_d;
  logic accepted, alloc, tag_hit, i_accepted;

  assign i_req = (Icache2mem_command != BUS_NONE);
  assign d_req = (Dcache2mem_command != BUS_NONE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign guard = (starve_cnt == 4'(STARVE_LIMIT));

  // Count consecutive cycles the Icache asks but is not accepted; saturate at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (i_req && !i_accepted) begin
      if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = |4'(STARVE_LIMIT);
  assign guard = 1'b0;
`endif

  assign grant_i    = i_req && (!d_req || guard);
  assign grant_d    = d_req && !grant_i;
  assign accepted   = (mem2proc_response != 4'd0);
  assign i_accepted = grant_i && accepted;
  assign alloc      = accepted &&
                      ((grant_d && (Dcache2mem_command == BUS_LOAD)) ||
                       (grant_i && (Icache2mem_command == BUS_LOAD)));
  assign tag_hit    = (mem2proc_tag != 4'd0) && valid[mem2proc_tag];

  // Request mux, response steering and tag routing; everything forced to 0 in reset.
  always_comb begin
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = 64'd0;
    mem2Icache_response = 4'd0;
    mem2Dcache_response = 4'd0;
    mem2Icache_data     = 64'd0;
    mem2Dcache_data     = 64'd0;
    mem2Icache_tag      = 4'd0;
    mem2Dcache_tag      = 4'd0;
    if (!reset) begin
      mem2Icache_data = mem2proc_data;
      mem2Dcache_data = mem2proc_data;
      if (grant_d) begin
        proc2mem_command    = Dcache2mem_command;
        proc2mem_addr       = Dcache2mem_addr;
        proc2mem_data       = Dcache2mem_data;
        mem2Dcache_response = mem2proc_response;
      end else if (grant_i) begin
        proc2mem_command    = Icache2mem_command;
        proc2mem_addr       = Icache2mem_addr;
        mem2Icache_response = mem2proc_response;
      end
      if (tag_hit) begin
        if (owner[mem2proc_tag]) mem2Dcache_tag = mem2proc_tag;
        else                     mem2Icache_tag = mem2proc_tag;
      end
    end
  end

  // Ownership table: free on return, then allocate so a same-cycle reuse keeps the entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      owner <= '0;
    end else begin
      if (tag_hit) valid[mem2proc_tag] <= 1'b0;
      if (alloc) begin
        valid[mem2proc_response] <= 1'b1;
        owner[mem2proc_response] <= grant_d;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus starve-guard and reset sequences.
module tb_mem_arbiter;

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] L = 2'd1;
  localparam logic [1:0] S = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icmd, dcmd;
  logic [31:0] iaddr, daddr;
  logic [63:0] ddata, mdata;
  logic [3:0]  resp, tag;
  logic [1:0]  p_cmd;
  logic [31:0] p_addr;
  logic [63:0] p_data, i_data, d_data;
  logic [3:0]  i_resp, d_resp, i_tag, d_tag;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .Icache2mem_command(icmd), .Icache2mem_addr(iaddr),
    .Dcache2mem_command(dcmd), .Dcache2mem_addr(daddr), .Dcache2mem_data(ddata),
    .mem2proc_response(resp), .mem2proc_data(mdata), .mem2proc_tag(tag),
    .proc2mem_command(p_cmd), .proc2mem_addr(p_addr), .proc2mem_data(p_data),
    .mem2Icache_response(i_resp), .mem2Dcache_response(d_resp),
    .mem2Icache_data(i_data), .mem2Dcache_data(d_data),
    .mem2Icache_tag(i_tag), .mem2Dcache_tag(d_tag)
  );

  typedef struct {
    logic [1:0]  icmd;
    logic [31:0] iaddr;
    logic [1:0]  dcmd;
    logic [31:0] daddr;
    logic [63:0] ddata;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_data;
    logic [3:0]  e_iresp;
    logic [3:0]  e_dresp;
    logic [3:0]  e_itag;
    logic [3:0]  e_dtag;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc,
                       input logic [31:0] da, input logic [63:0] dd, input logic [3:0] r,
                       input logic [3:0] t, input logic [63:0] md);
    icmd = ic; iaddr = ia; dcmd = dc; daddr = da; ddata = dd;
    resp = r; tag = t; mdata = md;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".cmd"},   64'(p_cmd),  64'd0);
    chk({name, ".addr"},  64'(p_addr), 64'd0);
    chk({name, ".data"},  p_data,      64'd0);
    chk({name, ".iresp"}, 64'(i_resp), 64'd0);
    chk({name, ".dresp"}, 64'(d_resp), 64'd0);
    chk({name, ".idata"}, i_data,      64'd0);
    chk({name, ".ddata"}, d_data,      64'd0);
    chk({name, ".itag"},  64'(i_tag),  64'd0);
    chk({name, ".dtag"},  64'(d_tag),  64'd0);
  endtask

  initial begin
    // Icache-only load / return / stale return
    vecs[0]  = '{L, 32'h100, N, 32'h0,  64'd0,   4'd3, 4'd0, L, 32'h100, 64'd0,   4'd3, 4'd0, 4'd0, 4'd0};
    vecs[1]  = '{N, 32'h0,   N, 32'h0,  64'd0,   4'd0, 4'd3, N, 32'h0,   64'd0,   4'd0, 4'd0, 4'd3, 4'd0};
    vecs[2]  = '{N, 32'h0,   N, 32'h0,  64'd0,   4'd0, 4'd3, N, 32'h0,   64'd0,   4'd0, 4'd0, 4'd0, 4'd0};
    // Simultaneous loads: Dcache first, Icache next cycle, returns steered
    vecs[3]  = '{L, 32'h200, L, 32'h10, 64'd0,   4'd4, 4'd0, L, 32'h10,  64'd0,   4'd0, 4'd4, 4'd0, 4'd0};
    vecs[4]  = '{L, 32'h200, N, 32'h0,  64'd0,   4'd6, 4'd0, L, 32'h200, 64'd0,   4'd6, 4'd0, 4'd0, 4'd0};
    vecs[5]  = '{N, 32'h0,   N, 32'h0,  64'd0,   4'd0, 4'd6, N, 32'h0,   64'd0,   4'd0, 4'd0, 4'd6, 4'd0};
    vecs[6]  = '{N, 32'h0,   N, 32'h0,  64'd0,   4'd0, 4'd4, N, 32'h0,   64'd0,   4'd0, 4'd0, 4'd0, 4'd4};
    // Store allocates nothing
    vecs[7]  = '{N, 32'h0,   S, 32'd16, 64'd107, 4'd7, 4'd0, S, 32'd16,  64'd107, 4'd0, 4'd7, 4'd0, 4'd0};
    vecs[8]  = '{N, 32'h0,   N, 32'h0,  64'd0,   4'd0, 4'd7, N, 32'h0,   64'd0,   4'd0, 4'd0, 4'd0, 4'd0};
    // Tag reuse in the same cycle
    vecs[9]  = '{L, 32'h300, N, 32'h0,  64'd0,   4'd5, 4'd0, L, 32'h300, 64'd0,   4'd5, 4'd0, 4'd0, 4'd0};
    vecs[10] = '{N, 32'h0,   L, 32'h20, 64'd0,   4'd5, 4'd5, L, 32'h20,  64'd0,   4'd0, 4'd5, 4'd5, 4'd0};
    vecs[11] = '{N, 32'h0,   N, 32'h0,  64'd0,   4'd0, 4'd5, N, 32'h0,   64'd0,   4'd0, 4'd0, 4'd0, 4'd5};
    vecs[12] = '{N, 32'h0,   N, 32'h0,  64'd0,   4'd0, 4'd5, N, 32'h0,   64'd0,   4'd0, 4'd0, 4'd0, 4'd0};

    // Reset state: outputs held at 0 even with live inputs
    reset = 1'b1;
    drive(L, 32'h100, S, 32'h8, 64'd55, 4'd3, 4'd3, 64'hABCD);
    @(negedge clock); #1;
    chk_all_zero("reset_init");
    @(negedge clock);
    reset = 1'b0;
    drive(N, 32'h0, N, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      drive(vecs[i].icmd, vecs[i].iaddr, vecs[i].dcmd, vecs[i].daddr, vecs[i].ddata,
            vecs[i].resp, vecs[i].tag, 64'h1111_0000_0000_0000 + 64'(i));
      #1;
      chk($sformatf("v%0d.cmd", i),   64'(p_cmd),  64'(vecs[i].e_cmd));
      chk($sformatf("v%0d.addr", i),  64'(p_addr), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d.data", i),  p_data,      vecs[i].e_data);
      chk($sformatf("v%0d.iresp", i), 64'(i_resp), 64'(vecs[i].e_iresp));
      chk($sformatf("v%0d.dresp", i), 64'(d_resp), 64'(vecs[i].e_dresp));
      chk($sformatf("v%0d.itag", i),  64'(i_tag),  64'(vecs[i].e_itag));
      chk($sformatf("v%0d.dtag", i),  64'(d_tag),  64'(vecs[i].e_dtag));
      chk($sformatf("v%0d.idata", i), i_data, 64'h1111_0000_0000_0000 + 64'(i));
      chk($sformatf("v%0d.ddata", i), d_data, 64'h1111_0000_0000_0000 + 64'(i));
    end

    // Starve guard: Dcache requests every cycle while Icache waits
    for (int k = 0; k < 7; k++) begin
      logic exp_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_i = (k == 4);
`else
      exp_i = 1'b0;
`endif
      @(negedge clock);
      drive(L, 32'h400, L, 32'h40, 64'd0, 4'd1, 4'd0, 64'd0);
      #1;
      chk($sformatf("starve%0d.addr", k),  64'(p_addr), exp_i ? 64'h400 : 64'h40);
      chk($sformatf("starve%0d.iresp", k), 64'(i_resp), exp_i ? 64'd1 : 64'd0);
      chk($sformatf("starve%0d.dresp", k), 64'(d_resp), exp_i ? 64'd0 : 64'd1);
    end

    // Reset with two outstanding loads (tag 8 Icache, tag 9 Dcache)
    @(negedge clock);
    drive(L, 32'h500, N, 32'h0, 64'd0, 4'd8, 4'd0, 64'd0);
    #1 chk("rst_seq.iresp", 64'(i_resp), 64'd8);
    @(negedge clock);
    drive(N, 32'h0, L, 32'h50, 64'd0, 4'd9, 4'd0, 64'd0);
    #1 chk("rst_seq.dresp", 64'(d_resp), 64'd9);
    @(negedge clock);
    reset = 1'b1;
    drive(L, 32'h600, S, 32'h58, 64'd77, 4'd2, 4'd8, 64'hBEEF);
    #1 chk_all_zero("reset_mid");
    @(negedge clock);
    reset = 1'b0;
    drive(N, 32'h0, N, 32'h0, 64'd0, 4'd0, 4'd8, 64'd0);
    #1;
    chk("drop8.itag", 64'(i_tag), 64'd0);
    chk("drop8.dtag", 64'(d_tag), 64'd0);
    @(negedge clock);
    drive(N, 32'h0, N, 32'h0, 64'd0, 4'd0, 4'd9, 64'd0);
    #1;
    chk("drop9.itag", 64'(i_tag), 64'd0);
    chk("drop9.dtag", 64'(d_tag), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
